// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the Simple RISC register-file sequencer.
// Optional trap build: REGFILE_SEQ_ILLEGAL_TRAP_EN adds the HALT state.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    StWait   = 3'd0,
    StDecode = 3'd1,
    StGetA   = 3'd2,
    StGetB   = 3'd3,
    StExec   = 3'd4,
    StWrReg  = 3'd5,
    StWrImm  = 3'd6
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
    ,
    StHalt   = 3'd7
`endif
  } state_e;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field IR[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Write-back source select
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and instruction classification for one IR word.
module instr_decode
  import regfile_seq_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  op,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        is_mov_imm,
  output logic        is_mov_reg,
  output logic        is_alu,
  output logic        is_cmp,
  output logic        is_mvn,
  output logic        illegal
);

  logic [2:0] opcode;

  // Field slicing, immediate sign extension and class decode
  always_comb begin
    opcode     = ir[15:13];
    op         = ir[12:11];
    rn         = ir[10:8];
    rd         = ir[7:5];
    rm         = ir[2:0];
    shift      = ir[4:3];
    sximm8     = {{8{ir[7]}}, ir[7:0]};
    is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    is_alu     = (opcode == OPC_ALU);
    is_cmp     = is_alu && (op == OP_CMP);
    is_mvn     = is_alu && (op == OP_MVN);
    illegal    = !(is_mov_imm || is_mov_reg || is_alu);
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Moore control FSM sequencing register file, A/B/C/status loads and ALU for one
// Simple RISC instruction at a time.
// Optional: REGFILE_SEQ_ILLEGAL_TRAP_EN traps illegal instructions in HALT with err.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  aluop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic        err
`endif
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;

  logic [2:0] rn, rd, rm;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, illegal;

  instr_decode u_decode (
    .ir         (ir_q),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .op         (op),
    .shift      (shift),
    .sximm8     (sximm8),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_alu     (is_alu),
    .is_cmp     (is_cmp),
    .is_mvn     (is_mvn),
    .illegal    (illegal)
  );

  assign aluop = op;

  // State register and IR; IR only loads on an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWait;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StWait && s) begin
        ir_q <= in;
      end
    end
  end

`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
  logic err_q;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state_q == StDecode && illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      StWait:   if (s) state_d = StDecode;
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWrImm;
        end else if (is_mov_reg || is_mvn) begin
          state_d = StGetB;
        end else if (is_alu) begin
          state_d = StGetA;
        end else begin
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StWait;
`endif
        end
      end
      StGetA:   state_d = StGetB;
      StGetB:   state_d = StExec;
      StExec:   state_d = is_cmp ? StWait : StWrReg;
      StWrReg:  state_d = StWait;
      StWrImm:  state_d = StWait;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
      StHalt:   state_d = StHalt;
`endif
      default:  state_d = StWait;
    endcase
  end

  // Moore control outputs decoded from state and IR only
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    case (state_q)
      StWait: w = 1'b1;
      StGetA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      StGetB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      StExec: begin
        asel  = is_mov_reg;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      StWrReg: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      StWrImm: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer.
// Define REGFILE_SEQ_ILLEGAL_TRAP_EN for both RTL and bench to test the trap build.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, aluop, shift;
  logic [15:0] sximm8;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
  logic        err;
`endif

  int vectors    = 0;
  int miscompares = 0;

  regfile_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .aluop    (aluop),
    .shift    (shift),
    .sximm8   (sximm8)
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs: {w,la,lb,lc,ls,write,asel,bsel,vsel,readnum,writenum}
  logic [15:0] ctrl;
  assign ctrl = {w, loada, loadb, loadc, loads, write, asel, bsel, vsel, readnum, writenum};

  function automatic logic [15:0] c(input logic wv, la, lb, lc, ls, wr, as,
                                    input logic [1:0] vs, input logic [2:0] rdn, wrn);
    return {wv, la, lb, lc, ls, wr, as, 1'b0, vs, rdn, wrn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'h0000;
    #3;
    vectors++;
    if (ctrl !== c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0) || sximm8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async: ctrl=%h sximm8=%h want ctrl=8000 sximm8=0000", ctrl, sximm8);
    end
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: err=%b want 0", err);
    end
`endif
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (ctrl !== c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0)) begin
      miscompares++;
      $display("FAIL reset_idle: ctrl=%h want 8000", ctrl);
    end
  endtask

  task automatic test_mov_imm();
    logic [15:0] exp [3];
    exp[0] = c(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // DECODE
    exp[1] = c(0, 0, 0, 0, 0, 1, 0, 2'b01, 3'd0, 3'd1);  // WR_IMM
    exp[2] = c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // WAIT
    in = 16'hD105;
    s  = 1'b1;
    tick();
    s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ctrl !== exp[i]) begin
        miscompares++;
        $display("FAIL mov_imm cyc%0d: ctrl=%h want %h", i, ctrl, exp[i]);
      end
      if (i == 1) begin
        vectors++;
        if (sximm8 !== 16'h0005) begin
          miscompares++;
          $display("FAIL mov_imm_sximm8: got %h want 0005", sximm8);
        end
      end
      tick();
    end
  endtask

  task automatic test_add();
    logic [15:0] exp [6];
    exp[0] = c(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // DECODE
    exp[1] = c(0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 3'd0);  // GET_A Rn=2
    exp[2] = c(0, 0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // GET_B Rm=0
    exp[3] = c(0, 0, 0, 1, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // EXEC
    exp[4] = c(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'd0, 3'd5);  // WR_REG Rd=5
    exp[5] = c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // WAIT
    in = 16'hA2A0;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    in = 16'hFFFF;  // must be ignored while busy
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (ctrl !== exp[i]) begin
        miscompares++;
        $display("FAIL add cyc%0d: ctrl=%h want %h", i, ctrl, exp[i]);
      end
      if (i == 3) begin
        vectors++;
        if (aluop !== 2'b00 || shift !== 2'b00) begin
          miscompares++;
          $display("FAIL add_aluop: aluop=%b shift=%b want 00 00", aluop, shift);
        end
      end
      tick();
    end
  endtask

  task automatic test_cmp();
    logic [15:0] exp [5];
    exp[0] = c(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // DECODE
    exp[1] = c(0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd1, 3'd0);  // GET_A Rn=1
    exp[2] = c(0, 0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // GET_B Rm=0
    exp[3] = c(0, 0, 0, 0, 1, 0, 0, 2'b00, 3'd0, 3'd0);  // EXEC loads only
    exp[4] = c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // WAIT
    in = 16'hA948;
    s  = 1'b1;
    tick();
    s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (ctrl !== exp[i]) begin
        miscompares++;
        $display("FAIL cmp cyc%0d: ctrl=%h want %h", i, ctrl, exp[i]);
      end
      if (i == 3) begin
        vectors++;
        if (aluop !== 2'b01 || shift !== 2'b01) begin
          miscompares++;
          $display("FAIL cmp_fields: aluop=%b shift=%b want 01 01", aluop, shift);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [8];
    exp[0] = c(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // DECODE  MOV R7,R3
    exp[1] = c(0, 0, 1, 0, 0, 0, 0, 2'b00, 3'd3, 3'd0);  // GET_B Rm=3
    exp[2] = c(0, 0, 0, 1, 0, 0, 1, 2'b00, 3'd0, 3'd0);  // EXEC asel
    exp[3] = c(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'd0, 3'd7);  // WR_REG Rd=7
    exp[4] = c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // single WAIT, start taken
    exp[5] = c(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // DECODE  MOV R1,#-1
    exp[6] = c(0, 0, 0, 0, 0, 1, 0, 2'b01, 3'd0, 3'd1);  // WR_IMM Rn=1
    exp[7] = c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0);  // WAIT
    in = 16'hC0E3;
    s  = 1'b1;
    tick();
    in = 16'hD1FF;  // next instruction, only sampled in the WAIT cycle
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ctrl !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b cyc%0d: ctrl=%h want %h", i, ctrl, exp[i]);
      end
      if (i == 2) begin
        vectors++;
        if (sximm8 !== 16'hFFE3) begin
          miscompares++;
          $display("FAIL b2b_ir_hold: sximm8=%h want FFE3", sximm8);
        end
      end
      if (i == 6) begin
        vectors++;
        if (sximm8 !== 16'hFFFF) begin
          miscompares++;
          $display("FAIL neg_imm_sximm8: got %h want FFFF", sximm8);
        end
      end
      if (i == 5) s = 1'b0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    in = 16'hA2A0;
    s  = 1'b1;
    tick();
    s = 1'b0;
    tick();
    tick();
    vectors++;
    if (ctrl !== c(0, 0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0)) begin
      miscompares++;
      $display("FAIL arst_in_getb: ctrl=%h want 2000", ctrl);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ctrl !== c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0) || sximm8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL arst_immediate: ctrl=%h sximm8=%h want 8000 0000", ctrl, sximm8);
    end
    #2;
    reset_n = 1'b1;
    tick();
    vectors++;
    if (ctrl !== c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0)) begin
      miscompares++;
      $display("FAIL arst_release: ctrl=%h want 8000", ctrl);
    end
  endtask

  task automatic test_illegal();
    in = 16'hE000;
    s  = 1'b1;
    tick();
    s = 1'b0;
    vectors++;
    if (ctrl !== c(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0)) begin
      miscompares++;
      $display("FAIL illegal_decode: ctrl=%h want 0000", ctrl);
    end
    tick();
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
    s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ctrl !== 16'h0000 || err !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_halt cyc%0d: ctrl=%h err=%b want 0000 1", i, ctrl, err);
      end
      tick();
    end
    s = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ctrl !== 16'h8000 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_reset_exit: ctrl=%h err=%b want 8000 0", ctrl, err);
    end
    #2;
    reset_n = 1'b1;
    tick();
`else
    vectors++;
    if (ctrl !== c(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 3'd0)) begin
      miscompares++;
      $display("FAIL illegal_nop: ctrl=%h want 8000", ctrl);
    end
    tick();
    vectors++;
    if (w !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_stay_wait: w=%b want 1", w);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_back_to_back();
    test_async_reset();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
